// File: rtl/wb_dma_copy.sv
// Wishbone classic-cycle block copier: one read then one write per word,
// aborting on responder err or when the ack watchdog expires.
module wb_dma_copy #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = DW >> 3,
   parameter int LW = 16,
   parameter int TO = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [AW-1:0] i_src,
   input  logic [AW-1:0] i_dst,
   input  logic [LW-1:0] i_len,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err,
   output logic [LW-1:0] o_count,
   output logic [AW-1:0] o_wb_adr,
   output logic [SW-1:0] o_wb_sel,
   output logic          o_wb_we,
   output logic [DW-1:0] o_wb_dat,
   input  logic [DW-1:0] i_wb_dat,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   input  logic          i_wb_ack,
   input  logic          i_wb_err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_RGAP = 3'd2,
      S_WR   = 3'd3,
      S_WGAP = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   localparam logic [AW-1:0] ALIGN_MASK = ~(AW'(SW - 1));
   localparam logic [AW-1:0] STEP       = AW'(SW);
   localparam logic [7:0]    TO_LIM     = 8'(TO);

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [LW-1:0] count_q, count_d;
   logic [DW-1:0] data_q, data_d;
   logic [7:0]    wd_q, wd_d;
   logic [7:0]    wd_inc_s;
   logic          err_q, err_d;
   logic [AW-1:0] adr_q, adr_d;
   logic          we_q, we_d;
   logic [DW-1:0] dat_q, dat_d;
   logic          cyc_q, cyc_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Next-state, datapath and registered-output next values.
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      count_d  = count_q;
      data_d   = data_q;
      wd_d     = wd_q;
      err_d    = err_q;
      wd_inc_s = wd_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               src_d   = i_src & ALIGN_MASK;
               dst_d   = i_dst & ALIGN_MASK;
               rem_d   = i_len;
               count_d = {LW{1'b0}};
               err_d   = 1'b0;
               wd_d    = 8'd0;
               if (i_len == {LW{1'b0}}) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_RD;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD, S_WR: begin
            // err wins over a simultaneous ack; the watchdog aborts the same way
            if (i_wb_err) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end else if (i_wb_ack) begin
               if (state_q == S_RD) begin
                  data_d  = i_wb_dat;
                  state_d = S_RGAP;
               end else begin
                  count_d = count_q + LW'(1);
                  src_d   = src_q + STEP;
                  dst_d   = dst_q + STEP;
                  rem_d   = rem_q - LW'(1);
                  state_d = S_WGAP;
               end
            end else begin
               wd_d = wd_inc_s;
               if (wd_inc_s == TO_LIM) begin
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  state_d = state_q;
               end
            end
         end
         S_RGAP: begin
            wd_d    = 8'd0;
            state_d = S_WR;
         end
         S_WGAP: begin
            if (rem_q != {LW{1'b0}}) begin
               wd_d    = 8'd0;
               state_d = S_RD;
            end else begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus outputs are decoded from the next state so they are registered
      // yet line up with the state; address/we/data hold while idle.
      cyc_d  = (state_d == S_RD) || (state_d == S_WR);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
      if (state_d == S_RD) begin
         adr_d = src_d;
         we_d  = 1'b0;
         dat_d = dat_q;
      end else if (state_d == S_WR) begin
         adr_d = dst_d;
         we_d  = 1'b1;
         dat_d = data_d;
      end else begin
         adr_d = adr_q;
         we_d  = we_q;
         dat_d = dat_q;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         src_q   <= {AW{1'b0}};
         dst_q   <= {AW{1'b0}};
         rem_q   <= {LW{1'b0}};
         count_q <= {LW{1'b0}};
         data_q  <= {DW{1'b0}};
         wd_q    <= 8'd0;
         err_q   <= 1'b0;
         adr_q   <= {AW{1'b0}};
         we_q    <= 1'b0;
         dat_q   <= {DW{1'b0}};
         cyc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         count_q <= count_d;
         data_q  <= data_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_busy   = busy_q;
   assign o_done   = done_q;
   assign o_err    = err_q;
   assign o_count  = count_q;
   assign o_wb_adr = adr_q;
   assign o_wb_sel = {SW{cyc_q}};
   assign o_wb_we  = we_q;
   assign o_wb_dat = dat_q;
   assign o_wb_cyc = cyc_q;
   assign o_wb_stb = cyc_q;

endmodule
